pipe_chain: RTL
===============

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (2..64).
REQ-002 SHALL have parameter CHANNELS, default 2, independent lanes carried in lockstep (1..16).
REQ-003 SHALL have parameter DATA_DEPTH, default 10, number of register stages (1..32).
REQ-004 SHALL have parameter COMB_DEPTH, default 3, mixing rounds per stage (0..32).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, synchronous clear of all in-flight data.
REQ-008 SHALL have port in_valid, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, input beat accepted when in_valid&&in_ready.
REQ-010 SHALL have port in_data, input, CHANNELS*WIDTH, lane c at bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, 1, output beat present.
REQ-012 SHALL have port out_ready, input, 1, sink accepts the beat.
REQ-013 SHALL have port out_data, output, CHANNELS*WIDTH, same lane packing.
REQ-014 SHALL have port occupancy, output, $clog2(DATA_DEPTH+1), valid stages held.

Function
REQ-015 Stage s (0..DATA_DEPTH-1) SHALL apply COMB_DEPTH rounds to each lane: x = rotl1(x) XOR K, K = (s*COMB_DEPTH + r) mod 2^WIDTH, r = 0..COMB_DEPTH-1; COMB_DEPTH=0 is pass-through.
REQ-016 All lanes SHALL use the same K; lanes SHALL never mix.
REQ-017 Each stage SHALL hold one valid bit and one data word; a stage loads when it is empty or its contents move downstream in the same cycle.
REQ-018 Last stage drives out_valid/out_data; contents leave on out_valid&&out_ready.
REQ-019 in_ready SHALL equal "stage 0 can load" per REQ-017 (combinational from out_ready through the chain); bubbles SHALL collapse.
REQ-020 Unstalled latency SHALL be exactly DATA_DEPTH cycles from accepted input to out_valid; throughput one beat per cycle.
REQ-021 With out_ready low and all stages valid, in_ready SHALL be 0 and out_data SHALL hold stable.
REQ-022 Beats SHALL exit in acceptance order; none dropped or duplicated.
REQ-023 occupancy SHALL be the count of valid stage bits, registered, range 0..DATA_DEPTH.
REQ-024 flush SHALL clear all valid bits next edge, override a simultaneous input accept (beat discarded), and force in_ready low in the flush cycle.
REQ-025 out_data SHALL not be required to be zero when out_valid is 0.

Reset
REQ-026 rst low SHALL asynchronously clear all valid bits, occupancy and data registers to 0; out_valid=0, in_ready=1 only after rst released.
REQ-027 Reset mid-stream SHALL discard all in-flight beats; first beat after release has latency DATA_DEPTH.

Configuration
REQ-028 Macro PIPE_CHAIN_PARITY_EN: when defined, each lane word SHALL carry an even-parity bit computed at input, transformed by rotating alongside data (parity recomputed after each round) and checked at output; adds output port parity_err (1 bit, sticky, cleared by rst or flush).
REQ-029 Without PIPE_CHAIN_PARITY_EN, no parity logic or parity_err port SHALL exist.

Structure
REQ-030 Package pipe_chain_pkg SHALL hold the round-constant function, rotl1 function and occupancy-width helper.
REQ-031 One sub-module pipe_chain_stage (one register stage, all lanes, parameter stage index) SHALL be instantiated DATA_DEPTH times by generate.

Verification
REQ-032 Defaults, WIDTH=8 CHANNELS=2, in_data=16'h0100 single beat, out_ready=1 -> out_valid exactly 10 cycles later, data equals reference model of REQ-015.
REQ-033 Stream 50 beats, out_ready=1 -> 50 consecutive out_valid cycles, order preserved, occupancy steady 10.
REQ-034 out_ready=0 for 20 cycles while in_valid=1 -> in_ready drops after 10 accepts, occupancy=10, out_data stable; release -> no loss.
REQ-035 flush asserted with occupancy=6 and in_valid=1 -> next cycle occupancy=0, out_valid=0, flushed beat never emitted.
REQ-036 rst low mid-stream for 1 cycle (async, between edges) -> outputs clear immediately; next beat latency 10.
REQ-037 With PIPE_CHAIN_PARITY_EN, force-flip one stage data bit -> parity_err=1 when that beat exits, stays 1 until flush.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
// Shared helpers for pipe_chain: round constants, rotate-left-by-one and occupancy width.
// Lanes up to 64 bits wide are carried in 64-bit containers; callers truncate to WIDTH.
package pipe_chain_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [63:0] lane_mask(input int w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return m;
    endfunction

    function automatic logic [63:0] rotl1(input logic [63:0] x, input int w);
        return ((x << 1) | (x >> (w - 1))) & lane_mask(w);
    endfunction

    function automatic logic [63:0] round_k(input int stage, input int comb_depth,
                                            input int r, input int w);
        logic [63:0] k;
        k = 64'(stage * comb_depth + r);
        return k & lane_mask(w);
    endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One register stage of pipe_chain: mixes every lane with this stage's rounds, then holds it.
// Parity tracking is compiled in only with PIPE_CHAIN_PARITY_EN.
module pipe_chain_stage
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int COMB_DEPTH = 3,
    parameter int STAGE      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         up_valid,
    input  logic [CHANNELS*WIDTH-1:0]    up_data,
`ifdef PIPE_CHAIN_PARITY_EN
    input  logic [CHANNELS-1:0]          up_par,
    output logic [CHANNELS-1:0]          par,
`endif
    input  logic                         down_ready,
    output logic                         valid,
    output logic [CHANNELS*WIDTH-1:0]    data
);

    logic [CHANNELS*WIDTH-1:0] mixed;
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic                      valid_q;
    logic                      can_load;

    always_comb begin
        logic [WIDTH-1:0] lane;
        lane  = '0;
        mixed = up_data;
        for (int c = 0; c < CHANNELS; c++) begin
            lane = up_data[c*WIDTH +: WIDTH];
            for (int r = 0; r < COMB_DEPTH; r++) begin
                lane = WIDTH'(rotl1(64'(lane), WIDTH) ^ round_k(STAGE, COMB_DEPTH, r, WIDTH));
            end
            mixed[c*WIDTH +: WIDTH] = lane;
        end
    end

    assign can_load = !valid_q || down_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (can_load) begin
            valid_q <= up_valid;
            if (up_valid) data_q <= mixed;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef PIPE_CHAIN_PARITY_EN
    // Rotation preserves parity, so only the XOR with K can flip it.
    logic                k_flip;
    logic [CHANNELS-1:0] par_q;

    always_comb begin
        k_flip = 1'b0;
        for (int r = 0; r < COMB_DEPTH; r++) begin
            k_flip = k_flip ^ (^round_k(STAGE, COMB_DEPTH, r, WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= '0;
        end else if (!flush && can_load && up_valid) begin
            par_q <= up_par ^ {CHANNELS{k_flip}};
        end
    end

    assign par = par_q;
`endif

endmodule

// File: rtl/pipe_chain.sv
// Elastic chain of DATA_DEPTH mixing stages with collapsing bubbles, flush and occupancy.
// Define PIPE_CHAIN_PARITY_EN to add per-lane parity and the sticky parity_err output.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int DATA_DEPTH = 10,
    parameter int COMB_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHANNELS*WIDTH-1:0]          in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CHANNELS*WIDTH-1:0]          out_data,
`ifdef PIPE_CHAIN_PARITY_EN
    output logic                               parity_err,
`endif
    output logic [$clog2(DATA_DEPTH+1)-1:0]    occupancy
);

    localparam int OCC_W = occ_width(DATA_DEPTH);

    logic [DATA_DEPTH-1:0]     v;
    logic [CHANNELS*WIDTH-1:0] d [DATA_DEPTH];
`ifdef PIPE_CHAIN_PARITY_EN
    logic [CHANNELS-1:0]       p [DATA_DEPTH];
    logic [CHANNELS-1:0]       in_par;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) in_par[c] = ^in_data[c*WIDTH +: WIDTH];
    end
`endif

    // A stage can load when it or anything below it is empty, or the sink drains the tail.
    for (genvar s = 0; s < DATA_DEPTH; s++) begin : g_stage
        logic                      up_valid;
        logic [CHANNELS*WIDTH-1:0] up_data;
        logic                      down_ready;
`ifdef PIPE_CHAIN_PARITY_EN
        logic [CHANNELS-1:0]       up_par;
`endif

        if (s == 0) begin : g_head
            assign up_valid = in_valid && in_ready;
            assign up_data  = in_data;
`ifdef PIPE_CHAIN_PARITY_EN
            assign up_par   = in_par;
`endif
        end else begin : g_body
            assign up_valid = v[s-1];
            assign up_data  = d[s-1];
`ifdef PIPE_CHAIN_PARITY_EN
            assign up_par   = p[s-1];
`endif
        end

        if (s == DATA_DEPTH - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_mid
            assign down_ready = out_ready || !(&v[DATA_DEPTH-1:s+1]);
        end

        pipe_chain_stage #(
            .WIDTH      (WIDTH),
            .CHANNELS   (CHANNELS),
            .COMB_DEPTH (COMB_DEPTH),
            .STAGE      (s)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
`ifdef PIPE_CHAIN_PARITY_EN
            .up_par     (up_par),
            .par        (p[s]),
`endif
            .down_ready (down_ready),
            .valid      (v[s]),
            .data       (d[s])
        );
    end

    assign in_ready  = rst && !flush && (out_ready || !(&v));
    assign out_valid = v[DATA_DEPTH-1];
    assign out_data  = d[DATA_DEPTH-1];

    logic accept;
    logic leave;
    assign accept = in_valid && in_ready;
    assign leave  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(leave);
        end
    end

`ifdef PIPE_CHAIN_PARITY_EN
    logic [CHANNELS-1:0] lane_bad;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            lane_bad[c] = (^out_data[c*WIDTH +: WIDTH]) ^ p[DATA_DEPTH-1][c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (flush) begin
            parity_err <= 1'b0;
        end else if (leave && |lane_bad) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule
